// File: rtl/ddr2_backend_seq_0.sv
// rtl/ddr2_backend_seq_0.sv - DDR2 backend test sequencer: write bursts, read back, repeat
// Every output is registered; decisions are made in the comb block and land one edge later.
module ddr2_backend_seq_0 #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned NUM_BURSTS = 8,
  parameter int unsigned RD_TIMEOUT = 1023
) (
  input  logic        clk0,
  input  logic        rst,
  input  logic        init_done,
  input  logic        app_af_afull,
  input  logic        app_wdf_afull,
  input  logic        read_data_valid,
  input  logic        cmp_error,
  output logic        bkend_wraddr_en,
  output logic        bkend_data_en,
  output logic        bkend_rd_data_valid,
  output logic        cmd_rd,
  output logic        phase_done,
  output logic [15:0] pass_cnt,
  output logic        error,
  output logic        timeout
);

  localparam int unsigned WBEATS = BURST_LEN / 2;
  localparam int unsigned RBEATS = NUM_BURSTS * WBEATS;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wbeat_q, wbeat_d;
  logic [8:0]  burst_q, burst_d;
  logic [11:0] rbeat_q, rbeat_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic        wraddr_en_q, wraddr_en_d;
  logic        data_en_q, data_en_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        phase_done_q, phase_done_d;
  logic        error_q, error_d;
  logic        timeout_q, timeout_d;
  logic        rd_valid_q;
  logic        goto_done;
  logic        rd_all;
  logic [11:0] rbeat_inc;

  always_comb begin
    state_d      = state_q;
    wbeat_d      = wbeat_q;
    burst_d      = burst_q;
    rbeat_d      = rbeat_q;
    idle_d       = idle_q;
    pass_cnt_d   = pass_cnt_q;
    wraddr_en_d  = 1'b0;
    data_en_d    = 1'b0;
    cmd_rd_d     = 1'b0;
    phase_done_d = 1'b0;
    error_d      = error_q | cmp_error;
    timeout_d    = timeout_q;
    goto_done    = 1'b0;
    rbeat_inc    = rbeat_q + {11'd0, read_data_valid};
    rd_all       = read_data_valid && (rbeat_inc == 12'(RBEATS));

    case (state_q)
      IDLE: if (init_done) state_d = WR_ADDR;
      WR_ADDR: begin
        if (!app_af_afull && !app_wdf_afull) begin
          wraddr_en_d = 1'b1;
          state_d     = WR_DATA;
        end
      end
      WR_DATA: begin
        if (!app_wdf_afull) begin
          data_en_d = 1'b1;
          if (wbeat_q + 4'd1 == 4'(WBEATS)) begin
            wbeat_d = '0;
            if (burst_q + 9'd1 < 9'(NUM_BURSTS)) begin
              burst_d = burst_q + 9'd1;
              state_d = WR_ADDR;
            end else begin
              burst_d = '0;
              rbeat_d = '0;
              state_d = RD_ADDR;
            end
          end else begin
            wbeat_d = wbeat_q + 4'd1;
          end
        end
      end
      RD_ADDR: begin
        rbeat_d = rbeat_inc;
        if (!app_af_afull) begin
          wraddr_en_d = 1'b1;
          cmd_rd_d    = 1'b1;
          burst_d     = burst_q + 9'd1;
          if (burst_q + 9'd1 == 9'(NUM_BURSTS)) begin
            idle_d  = '0;
            state_d = RD_WAIT;
          end
        end
        if (rd_all) goto_done = 1'b1;
      end
      RD_WAIT: begin
        rbeat_d = rbeat_inc;
        idle_d  = read_data_valid ? 16'd0 : idle_q + 16'd1;
        if (rd_all) begin
          goto_done = 1'b1;
        end else if (!read_data_valid && (idle_q + 16'd1 == 16'(RD_TIMEOUT))) begin
          timeout_d = 1'b1;
          goto_done = 1'b1;
        end
      end
      DONE:    state_d = WR_ADDR;
      default: state_d = IDLE;
    endcase

    // phase_done is raised on the edge into DONE so it coincides with that state
    if (goto_done) begin
      state_d      = DONE;
      phase_done_d = 1'b1;
      pass_cnt_d   = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
      wbeat_d      = '0;
      burst_d      = '0;
      rbeat_d      = '0;
      idle_d       = '0;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q      <= IDLE;
      wbeat_q      <= '0;
      burst_q      <= '0;
      rbeat_q      <= '0;
      idle_q       <= '0;
      pass_cnt_q   <= '0;
      wraddr_en_q  <= 1'b0;
      data_en_q    <= 1'b0;
      cmd_rd_q     <= 1'b0;
      phase_done_q <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbeat_q      <= wbeat_d;
      burst_q      <= burst_d;
      rbeat_q      <= rbeat_d;
      idle_q       <= idle_d;
      pass_cnt_q   <= pass_cnt_d;
      wraddr_en_q  <= wraddr_en_d;
      data_en_q    <= data_en_d;
      cmd_rd_q     <= cmd_rd_d;
      phase_done_q <= phase_done_d;
      error_q      <= error_d;
      timeout_q    <= timeout_d;
      rd_valid_q   <= read_data_valid;
    end
  end

  assign bkend_wraddr_en     = wraddr_en_q;
  assign bkend_data_en       = data_en_q;
  assign bkend_rd_data_valid = rd_valid_q;
  assign cmd_rd              = cmd_rd_q;
  assign phase_done          = phase_done_q;
  assign pass_cnt            = pass_cnt_q;
  assign error               = error_q;
  assign timeout             = timeout_q;

endmodule
